// File: rtl/page_end_render.sv
// End-of-game page renderer: latches the final score, converts it to BCD and draws
// title / label / score text as a 2-stage registered RGB565 stream.
// Optional macro PAGE_END_COUNTUP_EN: displayed score counts up one per frame in SHOW.
//
// state   | meaning
// IDLE    | page hidden, waiting for game_over or game_won
// CONVERT | double-dabble of the latched score, one shift per cycle
// SHOW    | page drawn until both game flags drop
module page_end_render #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int COORD_W      = 10,
  parameter int SCORE_W      = 16,
  parameter int DIGITS       = 5,
  parameter int TITLE_Y      = 32,
  parameter int LABEL_Y      = 112,
  parameter int SCORE_Y      = 144,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [COORD_W-1:0] screen_x,
  input  logic [COORD_W-1:0] screen_y,
  input  logic               frame_start,
  input  logic               game_over,
  input  logic               game_won,
  input  logic [SCORE_W-1:0] score,
  output logic [5:0]         glyph_code,
  output logic [3:0]         glyph_row,
  input  logic [15:0]        glyph_bits,
  output logic [15:0]        pix_data,
  output logic               busy
);

  localparam int BCD_RAW   = (SCORE_W * 3) / 10 + 1;
  localparam int BCD_D     = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
  localparam int CNT_W     = $clog2(SCORE_W + 1);
  localparam int BLK_W     = $clog2(BLINK_FRAMES + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);
  localparam int LOSE_LEFT  = H_RES / 2 - 64;
  localparam int WON_LEFT   = H_RES / 2 - 128;
  localparam int LABEL_LEFT = H_RES / 2 - 128;
  localparam int SCORE_LEFT = H_RES / 2 - 8 * DIGITS;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [5:0]  SPACE  = 6'd26;

  localparam logic [5:0] LOSE_TXT [8] = '{6'd24, 6'd14, 6'd20, 6'd26, 6'd3, 6'd8, 6'd4, 6'd3};
  localparam logic [5:0] WON_TXT [16] = '{6'd21, 6'd8, 6'd2, 6'd19, 6'd14, 6'd17, 6'd24, 6'd26,
                                          6'd0, 6'd2, 6'd7, 6'd8, 6'd4, 6'd21, 6'd4, 6'd3};
  localparam logic [5:0] LABEL_TXT [16] = '{6'd24, 6'd14, 6'd20, 6'd17, 6'd26, 6'd5, 6'd8, 6'd13,
                                            6'd0, 6'd11, 6'd26, 6'd18, 6'd2, 6'd14, 6'd17, 6'd4};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnv_cnt;
  logic [SCORE_W-1:0]   shreg;
  logic [BCD_D*4-1:0]   bcd, bcd_adj;
  logic                 score_ovf;
  logic                 won_q;
  logic [BLK_W-1:0]     blink_cnt;
  logic                 blink_white;
  logic [DIGITS*4-1:0]  target, disp;
  logic [DIGITS-1:0]    blank;
  logic                 start;

  assign start = game_over | game_won;
  assign busy  = (state == S_CONVERT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CONVERT;
      S_CONVERT: if (cnv_cnt == '0) state_nxt = start ? S_SHOW : S_IDLE;
      S_SHOW:    if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_D; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      cnv_cnt     <= '0;
      shreg       <= '0;
      bcd         <= '0;
      score_ovf   <= 1'b0;
      won_q       <= 1'b0;
      blink_cnt   <= '0;
      blink_white <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        shreg       <= score;
        bcd         <= '0;
        cnv_cnt     <= CNT_W'(SCORE_W - 1);
        score_ovf   <= 64'(score) > MAX_VAL;
        won_q       <= game_won & ~game_over;
        blink_cnt   <= BLK_W'(BLINK_FRAMES - 1);
        blink_white <= 1'b0;
      end else begin
        if (state == S_CONVERT) begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          cnv_cnt      <= cnv_cnt - 1'b1;
        end
        if (state != S_IDLE && frame_start) begin
          if (blink_cnt == '0) begin
            blink_cnt   <= BLK_W'(BLINK_FRAMES - 1);
            blink_white <= ~blink_white;
          end else begin
            blink_cnt <= blink_cnt - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      target[4*i +: 4] = score_ovf ? 4'd9 : bcd[4*i +: 4];
  end

`ifdef PAGE_END_COUNTUP_EN
  function automatic logic [DIGITS*4-1:0] bcd_inc(input logic [DIGITS*4-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      disp <= '0;
    else if (state == S_CONVERT && state_nxt == S_SHOW)
      disp <= '0;
    else if (state == S_SHOW && frame_start && disp != target)
      disp <= bcd_inc(disp);
  end
`else
  assign disp = target;
`endif

  // Slot 0 is the leftmost (most significant) digit; the last slot is never blanked.
  always_comb begin
    logic lz;
    lz = 1'b1;
    for (int s = 0; s < DIGITS; s++) begin
      lz       = lz & (disp[4*(DIGITS-1-s) +: 4] == 4'd0);
      blank[s] = lz && (s != DIGITS - 1);
    end
  end

  logic        s1_act;
  logic [5:0]  s1_code;
  logic [3:0]  s1_row, s1_col, ci, dig;
  logic [15:0] s1_fg;
  logic        dig_blank;
  int          xi, yi, t_left, t_len;

  always_comb begin
    s1_act    = 1'b0;
    s1_code   = SPACE;
    s1_row    = '0;
    s1_col    = '0;
    s1_fg     = BLACK;
    ci        = '0;
    dig       = '0;
    dig_blank = 1'b0;
    xi        = int'(screen_x);
    yi        = int'(screen_y);
    t_left    = won_q ? WON_LEFT : LOSE_LEFT;
    t_len     = won_q ? 16 : 8;
    if (state == S_SHOW && xi < H_RES && yi < V_RES) begin
      if (yi >= TITLE_Y && yi < TITLE_Y + 16 && xi >= t_left && xi < t_left + 16 * t_len) begin
        ci      = 4'((xi - t_left) >> 4);
        s1_act  = 1'b1;
        s1_code = won_q ? WON_TXT[ci] : LOSE_TXT[ci[2:0]];
        s1_row  = 4'(yi - TITLE_Y);
        s1_col  = 4'(xi - t_left);
        s1_fg   = won_q ? (blink_white ? WHITE : YELLOW) : RED;
      end else if (yi >= LABEL_Y && yi < LABEL_Y + 16 &&
                   xi >= LABEL_LEFT && xi < LABEL_LEFT + 256) begin
        ci      = 4'((xi - LABEL_LEFT) >> 4);
        s1_act  = 1'b1;
        s1_code = LABEL_TXT[ci];
        s1_row  = 4'(yi - LABEL_Y);
        s1_col  = 4'(xi - LABEL_LEFT);
        s1_fg   = WHITE;
      end else if (yi >= SCORE_Y && yi < SCORE_Y + 16 &&
                   xi >= SCORE_LEFT && xi < SCORE_LEFT + 16 * DIGITS) begin
        ci = 4'((xi - SCORE_LEFT) >> 4);
        for (int s = 0; s < DIGITS; s++) begin
          if (int'(ci) == s) begin
            dig       = disp[4*(DIGITS-1-s) +: 4];
            dig_blank = blank[s];
          end
        end
        s1_act  = 1'b1;
        s1_code = dig_blank ? SPACE : 6'd27 + {2'b00, dig};
        s1_row  = 4'(yi - SCORE_Y);
        s1_col  = 4'(xi - SCORE_LEFT);
        s1_fg   = WHITE;
      end
    end
  end

  logic [3:0]  col_q;
  logic [15:0] fg_q;
  logic        act_q;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      glyph_code <= SPACE;
      glyph_row  <= '0;
      col_q      <= '0;
      fg_q       <= BLACK;
      act_q      <= 1'b0;
      pix_data   <= BLACK;
    end else begin
      glyph_code <= s1_code;
      glyph_row  <= s1_row;
      col_q      <= s1_col;
      fg_q       <= s1_fg;
      act_q      <= s1_act;
      pix_data   <= (act_q && glyph_bits[4'd15 - col_q]) ? fg_q : BLACK;
    end
  end

endmodule

// File: tb/tb_page_end_render.sv
// Bench for page_end_render: a scoreboard of expected glyph codes and pixels built
// from a text model of the page, plus timing, blink, overflow and reset scenarios.
module tb_page_end_render;

  localparam int DIGITS = 5;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  screen_x, screen_y;
  logic        frame_start, game_over, game_won;
  logic [15:0] score;
  logic [16:0] score17;
  logic [5:0]  code_a, code_b;
  logic [3:0]  row_a, row_b;
  logic [15:0] bits_a, bits_b, pix_a, pix_b;
  logic        busy_a, busy_b;
  logic        force_en;
  logic [15:0] force_val;
  logic        sel;
  logic [5:0]  mon_code;
  logic [15:0] mon_pix;
  logic        mon_busy;

  int total = 0;
  int bad   = 0;

  bit m_show, m_won, m_white;
  int m_val;
  logic [15:0] exp_q[$];

  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] font(input logic [5:0] c, input logic [3:0] r);
    return {c, r, c} ^ 16'h5A3C;
  endfunction

  assign bits_a   = force_en ? force_val : font(code_a, row_a);
  assign bits_b   = force_en ? force_val : font(code_b, row_b);
  assign mon_code = sel ? code_b : code_a;
  assign mon_pix  = sel ? pix_b : pix_a;
  assign mon_busy = sel ? busy_b : busy_a;

  page_end_render dut_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .screen_x(screen_x), .screen_y(screen_y),
    .frame_start(frame_start), .game_over(game_over), .game_won(game_won), .score(score),
    .glyph_code(code_a), .glyph_row(row_a), .glyph_bits(bits_a), .pix_data(pix_a), .busy(busy_a));

  page_end_render #(.SCORE_W(17)) dut_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .screen_x(screen_x), .screen_y(screen_y),
    .frame_start(frame_start), .game_over(game_over), .game_won(game_won), .score(score17),
    .glyph_code(code_b), .glyph_row(row_b), .glyph_bits(bits_b), .pix_data(pix_b), .busy(busy_b));

  function automatic logic [5:0] char2code(input byte ch);
    if (ch == " ") return 6'd26;
    if (ch >= "0" && ch <= "9") return 6'(27 + ch - "0");
    return 6'(ch - "A");
  endfunction

  function automatic void model(input int x, input int y, output logic [5:0] code,
                                output logic [15:0] pix);
    string t;
    int left, top, ci, p;
    logic [15:0] fg, b;
    bit hit;
    code = 6'd26; pix = 16'h0000; hit = 0; left = 0; top = 0; fg = 16'h0000;
    if (!m_show || x >= 640 || y >= 480) return;
    if (y >= 32 && y < 48) begin
      t = m_won ? "VICTORY ACHIEVED" : "YOU DIED";
      left = m_won ? 192 : 256; top = 32;
      if (x >= left && x < left + 16 * t.len()) begin
        hit = 1; code = char2code(t[(x - left) / 16]);
        fg = m_won ? (m_white ? 16'hFFFF : 16'hFFE0) : 16'hF800;
      end
    end else if (y >= 112 && y < 128 && x >= 192 && x < 448) begin
      t = "YOUR FINAL SCORE"; left = 192; top = 112; hit = 1;
      code = char2code(t[(x - left) / 16]); fg = 16'hFFFF;
    end else if (y >= 144 && y < 160 && x >= 280 && x < 360) begin
      left = 280; top = 144; hit = 1; fg = 16'hFFFF;
      ci = (x - left) / 16; p = 1;
      for (int k = 0; k < DIGITS - 1 - ci; k++) p = p * 10;
      if (ci < DIGITS - 1 && m_val < p) code = 6'd26;
      else code = 6'(27 + (m_val / p) % 10);
    end
    if (hit) begin
      b = font(code, 4'(y - top));
      pix = b[15 - ((x - left) % 16)] ? fg : 16'h0000;
    end
  endfunction

  task automatic scan(input int y, input int x0, input int x1);
    logic [5:0] c, prev_code;
    logic [15:0] p, ep;
    int x;
    exp_q.delete();
    prev_code = 6'd26;
    for (int i = 0; i <= x1 - x0 + 2; i++) begin
      @(negedge vga_clk);
      if (i >= 2) begin
        ep = exp_q.pop_front();
        total++;
        if (mon_pix !== ep) begin
          bad++;
          $display("FAIL pix y=%0d x=%0d got=%h exp=%h", y, x0 + i - 2, mon_pix, ep);
        end
      end
      if (i >= 1) begin
        total++;
        if (mon_code !== prev_code) begin
          bad++;
          $display("FAIL glyph_code y=%0d x=%0d got=%0d exp=%0d", y, x0 + i - 1, mon_code, prev_code);
        end
      end
      x = (i <= x1 - x0) ? x0 + i : 1000;
      model(x, y, c, p);
      exp_q.push_back(p);
      prev_code = c;
      screen_x = 10'(x);
      screen_y = 10'(y);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic settle(input int n);
`ifdef PAGE_END_COUNTUP_EN
    for (int k = 0; k <= n; k++) pulse_frame();
`endif
  endtask

  task automatic wait_convert();
    int k;
    k = 0;
    while (!mon_busy && k < 100) begin @(negedge vga_clk); k++; end
    while (mon_busy && k < 200) begin @(negedge vga_clk); k++; end
    total++;
    if (k >= 200 || mon_busy) begin
      bad++;
      $display("FAIL convert_timeout got=busy_stuck exp=done");
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge vga_clk);
      if (mon_busy) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge vga_clk);
    total++;
    if (pix_a !== 16'h0000 || busy_a !== 1'b0 || code_a !== 6'd26 || row_a !== 4'd0) begin
      bad++;
      $display("FAIL reset_values got=%h/%b/%0d/%0d exp=0000/0/26/0", pix_a, busy_a, code_a, row_a);
    end
    sys_rst_n = 1'b1;
    count_busy(n);
    total++;
    if (n !== 16) begin bad++; $display("FAIL busy_len got=%0d exp=16", n); end
  endtask

  task automatic test_lose_render();
    m_show = 1; m_won = 0; m_white = 0; m_val = 1234;
    settle(1234);
    scan(35, 250, 388);
    scan(127, 188, 451);
    scan(144, 276, 363);
    scan(159, 276, 363);
    score = 16'd9999;
    repeat (5) @(negedge vga_clk);
    scan(150, 276, 363);
    scan(500, 250, 260);
  endtask

  task automatic test_latency();
    force_en = 1'b1; force_val = 16'h8000;
    screen_x = 10'd0; screen_y = 10'd0;
    repeat (3) @(negedge vga_clk);
    screen_x = 10'd256; screen_y = 10'd32;
    @(negedge vga_clk);
    total++;
    if (pix_a !== 16'h0000) begin bad++; $display("FAIL latency_1cyc got=%h exp=0000", pix_a); end
    screen_x = 10'd257;
    @(negedge vga_clk);
    total++;
    if (pix_a !== 16'hF800) begin bad++; $display("FAIL latency_2cyc got=%h exp=f800", pix_a); end
    @(negedge vga_clk);
    total++;
    if (pix_a !== 16'h0000) begin bad++; $display("FAIL latency_col1 got=%h exp=0000", pix_a); end
    force_en = 1'b0;
  endtask

  task automatic test_end_show();
    game_over = 1'b0; game_won = 1'b0;
    repeat (3) @(negedge vga_clk);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_a); end
    m_show = 0;
    scan(40, 250, 390);
  endtask

  task automatic test_won_blink();
    score = 16'd0; game_won = 1'b1;
    wait_convert();
    m_show = 1; m_won = 1; m_white = 0; m_val = 0;
    scan(150, 276, 363);
    scan(33, 188, 451);
    force_en = 1'b1; force_val = 16'hFFFF;
    screen_x = 10'd193; screen_y = 10'd33;
    for (int n = 0; n <= 61; n++) begin
      repeat (3) @(negedge vga_clk);
      if (n == 0 || n == 29 || n == 30 || n == 59 || n == 60 || n == 61) begin
        total++;
        if (pix_a !== (((n / 30) % 2 == 1) ? 16'hFFFF : 16'hFFE0)) begin
          bad++;
          $display("FAIL blink n=%0d got=%h exp=%h", n, pix_a, ((n / 30) % 2 == 1) ? 16'hFFFF : 16'hFFE0);
        end
      end
      pulse_frame();
    end
    force_en = 1'b0;
    m_white = 0;
    scan(40, 188, 451);
    game_won = 1'b0;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    score = 16'hFFFF; score17 = 17'd100000;
    game_over = 1'b1; game_won = 1'b1;
    wait_convert();
    m_show = 1; m_won = 0; m_white = 0; m_val = 99999;
    scan(36, 250, 388);
`ifndef PAGE_END_COUNTUP_EN
    scan(150, 276, 363);
    sel = 1'b0; m_val = 65535;
    scan(150, 276, 363);
`endif
    sel = 1'b0;
    game_over = 1'b0; game_won = 1'b0;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_countup();
    score = 16'd3; game_over = 1'b1;
    wait_convert();
    m_show = 1; m_won = 0;
    for (int f = 0; f < 6; f++) begin
`ifdef PAGE_END_COUNTUP_EN
      m_val = (f < 3) ? f : 3;
`else
      m_val = 3;
`endif
      scan(146, 276, 363);
      pulse_frame();
    end
    game_over = 1'b0;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_reset_mid();
    score = 16'd777; game_over = 1'b1;
    repeat (6) @(negedge vga_clk);
    sys_rst_n = 1'b0;
    @(negedge vga_clk);
    total++;
    if (busy_a !== 1'b0 || pix_a !== 16'h0000 || code_a !== 6'd26) begin
      bad++;
      $display("FAIL reset_mid got=%b/%h/%0d exp=0/0000/26", busy_a, pix_a, code_a);
    end
    game_over = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_mid_idle got=%b exp=0", busy_a); end
    m_show = 0;
    scan(120, 188, 451);
  endtask

  task automatic test_back_to_back();
    int n;
    game_won = 1'b1; n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge vga_clk);
      if (busy_a) n++;
      if (n == 3) game_won = 1'b0;
      if (n > 0 && !busy_a) break;
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL drop_busy_len got=%0d exp=16", n); end
    m_show = 0;
    scan(40, 188, 451);
    score = 16'd42; game_over = 1'b1;
    wait_convert();
    m_show = 1; m_won = 0; m_white = 0; m_val = 42;
    settle(42);
    scan(152, 276, 363);
    game_over = 1'b0;
    repeat (3) @(negedge vga_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; game_over = 1'b1; game_won = 1'b0;
    score = 16'd1234; score17 = 17'd0; frame_start = 1'b0;
    screen_x = 10'd0; screen_y = 10'd0;
    force_en = 1'b0; force_val = 16'h0000; sel = 1'b0;
    m_show = 0; m_won = 0; m_white = 0; m_val = 0;
    test_reset();
    test_lose_render();
    test_latency();
    test_end_show();
    test_won_blink();
    test_overflow();
    test_countup();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
